// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader (sync, length, payload, checksum) that
// writes little-endian 32-bit words to the instruction memory and holds the core meanwhile.
module imem_loader #(
    parameter int         MEM_SIZE  = 256,
    parameter int         ADDR_W    = $clog2(MEM_SIZE),
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_waddr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [15:0]       o_words_loaded
);
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_ERR} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_len;
    logic [1:0]  r_idx;
    logic [23:0] r_word;
    logic [7:0]  r_csum;
    logic        w_acc;
    logic [15:0] w_len;
    logic [15:0] w_words_inc;
    assign w_acc       = i_rx_valid && o_rx_ready;
    assign w_len       = {i_rx_data, r_len[7:0]};
    assign w_words_inc = o_words_loaded + 16'd1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next     = r_state;
        o_rx_ready = r_state != S_WRITE;
        o_imem_we  = r_state == S_WRITE;
        case (r_state)
            S_IDLE:   if (w_acc && i_rx_data == SYNC_BYTE) w_next = S_LEN_LO;
            S_LEN_LO: if (w_acc) w_next = S_LEN_HI;
            S_LEN_HI: if (w_acc) w_next = (w_len == 16'd0 || w_len > 16'(MEM_SIZE)) ? S_ERR : S_DATA;
            S_DATA:   if (w_acc && r_idx == 2'd3) w_next = S_WRITE;
            S_WRITE:  w_next = (w_words_inc == r_len) ? S_CSUM : S_DATA;
            S_CSUM:   if (w_acc) w_next = (i_rx_data == r_csum) ? S_IDLE : S_ERR;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end
    // Bytes shift in from the top so the fourth byte completes the word in LSB-first order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len          <= '0;
            r_idx          <= '0;
            r_word         <= '0;
            r_csum         <= '0;
            o_imem_waddr   <= '0;
            o_imem_wdata   <= '0;
            o_cpu_hold     <= 1'b0;
            o_load_done    <= 1'b0;
            o_load_err     <= 1'b0;
            o_words_loaded <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_acc && i_rx_data == SYNC_BYTE) begin
                    o_cpu_hold     <= 1'b1;
                    o_load_done    <= 1'b0;
                    o_load_err     <= 1'b0;
                    o_words_loaded <= '0;
                    r_csum         <= '0;
                end
                S_LEN_LO: if (w_acc) r_len[7:0] <= i_rx_data;
                S_LEN_HI: if (w_acc) begin
                    r_len[15:8] <= i_rx_data;
                    r_idx       <= '0;
                end
                S_DATA: if (w_acc) begin
                    r_csum <= r_csum + i_rx_data;
                    r_idx  <= r_idx + 2'd1;
                    r_word <= {i_rx_data, r_word[23:8]};
                    if (r_idx == 2'd3) begin
                        o_imem_wdata <= {i_rx_data, r_word};
                        o_imem_waddr <= o_words_loaded[ADDR_W-1:0];
                    end
                end
                S_WRITE: o_words_loaded <= w_words_inc;
                S_CSUM: if (w_acc && i_rx_data == r_csum) begin
                    o_load_done <= 1'b1;
                    o_cpu_hold  <= 1'b0;
                end
                S_ERR: o_load_err <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level model builds byte stream, expected writes and final flags;
// one negedge process checks write handshake, write contents and cpu_hold every cycle.
module tb_imem_loader;
    localparam int MEM_SIZE = 256;
    localparam int ADDR_W   = 8;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready, imem_we, cpu_hold, load_done, load_err;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [15:0]       words_loaded;
    int checks = 0;
    int errors = 0;
    logic [7:0]        tx_data[$];
    logic              tx_wend[$];
    int                tx_hold[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_word[$];
    logic              m_done, m_err, m_hold;
    logic [15:0]       m_words;
    logic [7:0]        m_csum;
    logic              we_due = 1'b0;
    int                hold_exp = 0;
    logic              gaps = 1'b0;

    imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready), .o_imem_we(imem_we), .o_imem_waddr(imem_waddr),
        .o_imem_wdata(imem_wdata), .o_cpu_hold(cpu_hold), .o_load_done(load_done),
        .o_load_err(load_err), .o_words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic e, input int h);
        tx_data.push_back(d);
        tx_wend.push_back(e);
        tx_hold.push_back(h);
    endtask

    // Model: a frame with legal length writes word i to address i and releases the core
    // only on a matching checksum; an illegal length writes nothing and rejects.
    task automatic build_frame(input logic [15:0] len, input logic [31:0] w[$], input logic [7:0] adj);
        logic [7:0]  cs;
        logic [31:0] t;
        logic [7:0]  b8;
        cs = '0;
        push(8'hA5, 1'b0, 1);
        push(len[7:0], 1'b0, 1);
        push(len[15:8], 1'b0, 1);
        if (len != 0 && len <= MEM_SIZE) begin
            for (int i = 0; i < int'(len); i++) begin
                t = w[i];
                for (int b = 0; b < 4; b++) begin
                    b8 = t[8*b +: 8];
                    cs = cs + b8;
                    push(b8, b == 3, 1);
                end
                exp_addr.push_back(ADDR_W'(i));
                exp_word.push_back(t);
            end
            push(cs + adj, 1'b0, adj == 0 ? 0 : 1);
            m_done  = adj == 0;
            m_err   = adj != 0;
            m_hold  = adj != 0;
            m_words = len;
        end else begin
            m_done  = 1'b0;
            m_err   = 1'b1;
            m_hold  = 1'b1;
            m_words = '0;
        end
        m_csum = cs;
    endtask

    task automatic send(input int n);
        logic [7:0] d;
        logic       e;
        int         h, tries, g;
        for (int k = 0; k < n; k++) begin
            d = tx_data.pop_front();
            e = tx_wend.pop_front();
            h = tx_hold.pop_front();
            tries = 0;
            @(negedge clk);
            rx_data  = d;
            rx_valid = 1'b1;
            while (!rx_ready && tries < 10) begin
                @(negedge clk);
                tries++;
            end
            if (!rx_ready) check("ready_timeout", rx_ready, 1);
            @(posedge clk);
            we_due = e;
            if (h >= 0) hold_exp = h;
            if (gaps) begin
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                    repeat (g - 1) @(negedge clk);
                end
            end
        end
    endtask

    task automatic finish_frame();
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("load_done", load_done, m_done);
        check("load_err", load_err, m_err);
        check("cpu_hold_final", cpu_hold, m_hold);
        check("words_loaded", words_loaded, m_words);
        check("writes_drained", exp_addr.size(), 0);
    endtask

    task automatic run_frame(input logic [15:0] len, input logic [31:0] w[$], input logic [7:0] adj);
        build_frame(len, w, adj);
        send(tx_data.size());
        finish_frame();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 1);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_waddr"}, imem_waddr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_err"}, load_err, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ready_vs_we", rx_ready, !imem_we);
                check("we_timing", imem_we, we_due);
                we_due = 1'b0;
                if (hold_exp >= 0) check("cpu_hold", cpu_hold, hold_exp[0]);
                if (imem_we) begin
                    check("write_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) begin
                        check("waddr", imem_waddr, exp_addr.pop_front());
                        check("wdata", imem_wdata, exp_word.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
        // basic load
        w = '{32'h03500113, 32'h03600193};
        build_frame(16'd2, w, 8'd0);
        check("model_csum", m_csum, 8'h5E);
        send(tx_data.size());
        finish_frame();
        check("t1_waddr", imem_waddr, 1);
        check("t1_wdata", imem_wdata, 32'h03600193);
        check("t1_done", load_done, 1);
        check("t1_hold", cpu_hold, 0);
        check("t1_words", words_loaded, 2);
        // bad checksum
        run_frame(16'd2, w, 8'd1);
        check("t2_err", load_err, 1);
        check("t2_done", load_done, 0);
        check("t2_hold", cpu_hold, 1);
        // length limits
        w.delete();
        run_frame(16'd0, w, 8'd0);
        check("t3_len0_err", load_err, 1);
        run_frame(16'h0101, w, 8'd0);
        check("t3_len257_err", load_err, 1);
        for (int i = 0; i < MEM_SIZE; i++) w.push_back($urandom);
        run_frame(16'd256, w, 8'd0);
        check("t3_last_waddr", imem_waddr, 255);
        check("t3_done", load_done, 1);
        // garbage then a frame with random valid gaps
        push(8'h00, 1'b0, -1);
        push(8'hFF, 1'b0, -1);
        push(8'h5A, 1'b0, -1);
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        gaps = 1'b1;
        run_frame(16'd3, w, 8'd0);
        gaps = 1'b0;
        check("t4_words", words_loaded, 3);
        // asynchronous reset after 2 bytes of word 1
        w.delete();
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        build_frame(16'd2, w, 8'd0);
        send(3 + 4 + 2);
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        tx_data.delete();
        tx_wend.delete();
        tx_hold.delete();
        exp_addr.delete();
        exp_word.delete();
        we_due   = 1'b0;
        hold_exp = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        w.delete();
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        run_frame(16'd2, w, 8'd0);
        check("t5_words", words_loaded, 2);
        check("t5_last_waddr", imem_waddr, 1);
        // reload after error
        w.delete();
        w.push_back(32'hDEADBEEF);
        run_frame(16'd1, w, 8'd3);
        check("t6_err", load_err, 1);
        run_frame(16'd1, w, 8'd0);
        check("t6_err_cleared", load_err, 0);
        check("t6_done", load_done, 1);
        check("t6_hold", cpu_hold, 0);
        check("t6_wdata", imem_wdata, 32'hDEADBEEF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
